pulse_sweep_sched: RTL

Sweep scheduler for the pulse-mask datapath. It steps the pulse divider (period in clocks) from a start value to a stop value in signed increments, dwelling a programmable number of pulse periods at each step. Each divider value is issued with its derived duty count, and updates land only on period boundaries. It sits between the Control registers / ExtTrig and the pulse-mask generator inside CustomWrapper.

---
 rtl/pulse_sweep_pkg.sv | 26 ++
 rtl/pulse_period_counter.sv | 41 ++++
 rtl/pulse_sweep_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pulse_sweep_pkg.sv
// Shared definitions for the pulse sweep scheduler: state codes, duty scaling and
// divider clamping helpers (computed at a fixed 64-bit width, callers truncate).
package pulse_sweep_pkg;

  localparam int unsigned DUTY_SHIFT = 8;
  localparam int unsigned CALC_W     = 64;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  // A divider of 0 would stall the period counter, so it behaves as 1.
  function automatic logic [CALC_W-1:0] clamp_div(input logic [CALC_W-1:0] v);
    return (v == '0) ? CALC_W'(1) : v;
  endfunction

  function automatic logic [CALC_W-1:0] duty_of(input logic [CALC_W-1:0] div,
                                                input logic [7:0]        frac);
    logic [CALC_W-1:0] prod;
    prod = div * CALC_W'(frac);
    return prod >> DUTY_SHIFT;
  endfunction

endpackage

// File: rtl/pulse_period_counter.sv
// Period and dwell counters: flags the first cycle of each pulse period and the
// terminal cycle of the last period of a step.
module pulse_period_counter #(
  parameter int unsigned DIV_W  = 32,
  parameter int unsigned HOLD_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear,
  input  logic              run,
  input  logic [DIV_W-1:0]  divider,
  input  logic [HOLD_W-1:0] hold,
  output logic              period_start,
  output logic              step_tick
);

  logic [DIV_W-1:0]  cnt_q;
  logic [HOLD_W-1:0] dwell_q;
  logic              terminal;
  logic              last_period;

  assign terminal     = (cnt_q == divider - DIV_W'(1));
  assign last_period  = (dwell_q == hold - HOLD_W'(1));
  assign period_start = run & (cnt_q == '0);
  assign step_tick    = run & terminal & last_period;

  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      cnt_q   <= '0;
      dwell_q <= '0;
    end else if (run) begin
      if (terminal) begin
        cnt_q   <= '0;
        dwell_q <= last_period ? '0 : dwell_q + HOLD_W'(1);
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/pulse_sweep_sched.sv
// Sweep scheduler: steps the pulse divider from start to stop, dwelling a number of
// periods per step; new divider/duty values land only on period boundaries.
module pulse_sweep_sched
  import pulse_sweep_pkg::*;
#(
  parameter int unsigned DIV_W  = 32,
  parameter int unsigned HOLD_W = 16,
  parameter int unsigned IDX_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              trig,
  input  logic              abort,
  input  logic [DIV_W-1:0]  start_div,
  input  logic [DIV_W-1:0]  stop_div,
  input  logic [DIV_W-1:0]  step_div,
  input  logic [HOLD_W-1:0] hold_periods,
  input  logic [7:0]        duty_frac,
  input  logic              continuous,
  input  logic              retrig_en,
  output logic [DIV_W-1:0]  divider_out,
  output logic [DIV_W-1:0]  duty_out,
  output logic              period_start,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  step_index
);

  localparam int unsigned NW = DIV_W + 2;

  state_t            state_q, state_d;
  logic              trig_q, trig_edge;
  logic [DIV_W-1:0]  start_q, stop_q, step_q;
  logic [HOLD_W-1:0] hold_q;
  logic [7:0]        frac_q;
  logic              cont_q;
  logic [DIV_W-1:0]  div_q, duty_q, div_d, duty_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              latch_cfg, load_start, load_wrap, load_next, load_any;
  logic              step_tick;
  logic signed [NW-1:0] next_s;
  logic              step_pos, step_neg, out_of_range, at_end;
  logic [7:0]        frac_src;

  assign trig_edge = trig & ~trig_q;

  // Two guard bits: the sign bit catches underflow, the next one catches overflow.
  assign next_s       = $signed({2'b00, div_q}) + $signed({{2{step_q[DIV_W-1]}}, step_q});
  assign step_neg     = step_q[DIV_W-1];
  assign step_pos     = ~step_q[DIV_W-1] & (step_q != '0);
  assign out_of_range = next_s[NW-1] | next_s[NW-2];
  assign at_end       = (step_q == '0) | out_of_range
                      | (step_pos & (next_s[DIV_W-1:0] > stop_q))
                      | (step_neg & (next_s[DIV_W-1:0] < stop_q));

  always_comb begin
    state_d    = state_q;
    latch_cfg  = 1'b0;
    load_start = 1'b0;
    load_wrap  = 1'b0;
    load_next  = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (trig_edge) begin
            state_d    = StRun;
            latch_cfg  = 1'b1;
            load_start = 1'b1;
          end
        end
        StRun: begin
          if (trig_edge && retrig_en) begin
            latch_cfg  = 1'b1;
            load_start = 1'b1;
          end else if (step_tick) begin
            if (!at_end)     load_next = 1'b1;
            else if (cont_q) load_wrap = 1'b1;
            else             state_d   = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign load_any = load_start | load_wrap | load_next;
  assign frac_src = load_start ? duty_frac : frac_q;

  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (load_start) begin
      div_d = DIV_W'(clamp_div(CALC_W'(start_div)));
      idx_d = '0;
    end else if (load_wrap) begin
      div_d = DIV_W'(clamp_div(CALC_W'(start_q)));
      idx_d = '0;
    end else if (load_next) begin
      div_d = DIV_W'(clamp_div(CALC_W'(next_s[DIV_W-1:0])));
      idx_d = (&idx_q) ? idx_q : idx_q + IDX_W'(1);
    end
    duty_d = DIV_W'(duty_of(CALC_W'(div_d), frac_src));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      trig_q  <= 1'b0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      hold_q  <= '0;
      frac_q  <= '0;
      cont_q  <= 1'b0;
      div_q   <= '0;
      duty_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig;
      if (latch_cfg) begin
        start_q <= start_div;
        stop_q  <= stop_div;
        step_q  <= step_div;
        hold_q  <= (hold_periods == '0) ? HOLD_W'(1) : hold_periods;
        frac_q  <= duty_frac;
        cont_q  <= continuous;
      end
      if (load_any) begin
        div_q  <= div_d;
        duty_q <= duty_d;
        idx_q  <= idx_d;
      end
    end
  end

  pulse_period_counter #(
    .DIV_W  (DIV_W),
    .HOLD_W (HOLD_W)
  ) u_period_counter (
    .Clk          (Clk),
    .Reset        (Reset),
    .clear        (load_start),
    .run          (state_q == StRun),
    .divider      (div_q),
    .hold         (hold_q),
    .period_start (period_start),
    .step_tick    (step_tick)
  );

  assign divider_out = div_q;
  assign duty_out    = duty_q;
  assign step_index  = idx_q;
  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);

endmodule
